// File: rtl/jk_bank_if.sv
// Handshake and bank-side signals between a controller, jk_bank_driver and
// an external JK flip-flop bank.
interface jk_bank_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic [WIDTH-1:0] q_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [RW-1:0]    retry_cnt;

  // master: controller plus bank; slave: the driver block
  modport master (
    output in_valid, target, q_in,
    input  in_ready, j_out, k_out, busy, done, err, retry_cnt
  );

  modport slave (
    input  in_valid, target, q_in,
    output in_ready, j_out, k_out, busy, done, err, retry_cnt
  );
endinterface

// File: rtl/jk_bank_driver.sv
// Drives J/K of an external JK bank toward a requested word: one-cycle drive,
// one-cycle readback check, bounded retries, done/err pulse.
module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input logic     clk,
  input logic     rst_n,
  jk_bank_if.slave bus
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic [RW-1:0]    rc_q, rc_d;
  logic             done_q, done_d, err_q, err_d;
  logic             live_q;
  logic             accept;

  // live_q keeps in_ready low until the first edge after reset release
  assign accept = (state_q == IDLE) && live_q && bus.in_valid;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    rc_d    = rc_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = bus.target;
          rc_d    = '0;
          j_d     = bus.target & ~bus.q_in;
          k_d     = ~bus.target & bus.q_in;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        if (bus.q_in == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (rc_q < RW'(MAX_RETRY)) begin
          rc_d    = rc_q + 1'b1;
          j_d     = tgt_q & ~bus.q_in;
          k_d     = ~tgt_q & bus.q_in;
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      rc_q    <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      rc_q    <= rc_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  assign bus.in_ready  = live_q && (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.j_out     = j_q;
  assign bus.k_out     = k_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.retry_cnt = rc_q;
endmodule

// File: tb/tb_jk_bank_driver.sv
// Random and directed stimulus against a JK bank model plus a transaction-level
// reference that predicts every driver output each cycle.
module tb_jk_bank_driver;
  localparam int W  = 4;
  localparam int MR = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  jk_bank_if #(.WIDTH(W), .MAX_RETRY(MR)) bus ();
  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic         iv        = 1'b0;
  logic [W-1:0] tgt_in    = '0;
  logic [W-1:0] bank      = '0;
  logic [W-1:0] load_val  = '0;
  logic         load_en   = 1'b0;
  logic         stuck     = 1'b0;
  logic         fail_once = 1'b0;
  logic         failed    = 1'b0;

  assign bus.in_valid = iv;
  assign bus.target   = tgt_in;
  assign bus.q_in     = bank;

  // External bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bit0 or one lost update
  always @(posedge clk) begin
    if (load_en) begin
      bank   <= load_val;
      failed <= 1'b0;
    end else if ((bus.j_out | bus.k_out) != '0) begin
      if (fail_once && !failed) failed <= 1'b1;
      else bank <= ((bus.j_out & ~bank) | (~bus.k_out & bank)) & ~{{(W-1){1'b0}}, stuck};
    end
  end

  // Reference: a transaction is "attempt = drive then check"; outcome from bank vs target
  logic         m_busy, m_ph, m_ready, m_done, m_err;
  logic [W-1:0] m_tgt;
  int           m_rc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_ph <= 1'b0; m_ready <= 1'b0;
      m_done <= 1'b0; m_err <= 1'b0; m_tgt <= '0; m_rc <= 0;
    end else begin
      m_done  <= 1'b0;
      m_err   <= 1'b0;
      m_ready <= 1'b1;
      if (!m_busy) begin
        if (m_ready && iv) begin
          m_busy <= 1'b1; m_ph <= 1'b0; m_tgt <= tgt_in; m_rc <= 0;
        end
      end else if (!m_ph) m_ph <= 1'b1;
      else if (bank == m_tgt) begin m_done <= 1'b1; m_busy <= 1'b0; end
      else if (m_rc < MR) begin m_rc <= m_rc + 1; m_ph <= 1'b0; end
      else begin m_err <= 1'b1; m_busy <= 1'b0; end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic [W-1:0] ej, ek;
    forever begin
      @(negedge clk);
      ej = (m_busy && !m_ph) ? (m_tgt & ~bank) : '0;
      ek = (m_busy && !m_ph) ? (~m_tgt & bank) : '0;
      chk("j_out", bus.j_out, ej);
      chk("k_out", bus.k_out, ek);
      chk("no_toggle", bus.j_out & bus.k_out, 0);
      chk("busy", bus.busy, m_busy);
      chk("in_ready", bus.in_ready, m_ready && !m_busy);
      chk("done", bus.done, m_done);
      chk("err", bus.err, m_err);
      chk("done_err_excl", bus.done & bus.err, 0);
      chk("retry_cnt", bus.retry_cnt, m_rc);
    end
  end

  task automatic set_bank(input logic [W-1:0] v);
    @(negedge clk); load_val = v; load_en = 1'b1;
    @(negedge clk); load_en = 1'b0;
  endtask

  // Returns at the negedge of the DRIVE cycle
  task automatic send(input logic [W-1:0] t);
    @(negedge clk); iv = 1'b1; tgt_in = t;
    @(negedge clk); iv = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (bus.busy && c < maxc) begin @(negedge clk); c++; end
    chk("wait_idle_timeout", bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] seq [3];
    int drives, lat, idx;
    logic sd, se, fin;
    seq[0] = 4'b0011; seq[1] = 4'b1100; seq[2] = 4'b0000;

    #1 rst_n = 1'b0;
    @(negedge clk); #2;
    chk("rst_j", bus.j_out, 0);
    chk("rst_k", bus.k_out, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rc", bus.retry_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", bus.in_ready, 1);

    // 0000 -> 1010: all sets
    set_bank(4'b0000);
    send(4'b1010);
    chk("t1_j", bus.j_out, 4'b1010);
    chk("t1_k", bus.k_out, 4'b0000);
    @(negedge clk);
    chk("t1_bank", bank, 4'b1010);
    @(negedge clk);
    chk("t1_done", bus.done, 1);
    chk("t1_rc", bus.retry_cnt, 0);
    chk("t1_ready", bus.in_ready, 1);

    // 1111 -> 0101: resets only
    set_bank(4'b1111);
    send(4'b0101);
    chk("t2_j", bus.j_out, 4'b0000);
    chk("t2_k", bus.k_out, 4'b1010);
    wait_idle(10);
    chk("t2_done", bus.done, 1);
    chk("t2_bank", bank, 4'b0101);

    // Every (q, target) pair, including equal ones with J=K=0
    for (int q = 0; q < 16; q++)
      for (int t = 0; t < 16; t++) begin
        set_bank(W'(q));
        send(W'(t));
        wait_idle(10);
        chk("scan_done", bus.done, 1);
      end

    // bit0 stuck at 0: three drives then err
    stuck = 1'b1;
    set_bank(4'b0000);
    send(4'b0001);
    drives = 0; sd = 1'b0; se = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.j_out == 4'b0001) drives++;
      if (bus.done) sd = 1'b1;
      if (bus.err) begin se = 1'b1; break; end
      @(negedge clk);
    end
    chk("stuck_drives", drives, 3);
    chk("stuck_err", se, 1);
    chk("stuck_nodone", sd, 0);
    chk("stuck_rc", bus.retry_cnt, 2);
    @(negedge clk);
    chk("stuck_rc_hold", bus.retry_cnt, 2);
    stuck = 1'b0;

    // First update lost, then healthy: one retry, latency 5
    fail_once = 1'b1;
    set_bank(4'b0000);
    send(4'b1100);
    lat = 1;
    while (!bus.done && lat < 12) begin @(negedge clk); lat++; end
    chk("once_latency", lat, 5);
    chk("once_rc", bus.retry_cnt, 1);
    fail_once = 1'b0;

    // in_valid held high; garbage targets while busy must not be latched
    set_bank(4'b0101);
    @(negedge clk); iv = 1'b1; tgt_in = seq[0]; idx = 1; fin = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        chk("b2b_done_cycle", bus.done, 1);
        if (idx < 3) begin tgt_in = seq[idx]; idx++; end
        else begin iv = 1'b0; fin = 1'b1; break; end
      end else tgt_in = W'($urandom);
    end
    chk("b2b_finished", fin, 1);
    chk("b2b_bank", bank, 4'b0000);
    iv = 1'b0;

    // Reset during DRIVE
    set_bank(4'b0000);
    send(4'b1000);
    chk("rmid_j", bus.j_out, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_j_clr", bus.j_out, 0);
    chk("rmid_k_clr", bus.k_out, 0);
    @(negedge clk);
    chk("rmid_bank", bank, 4'b0000);
    chk("rmid_done", bus.done, 0);
    chk("rmid_err", bus.err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rmid_ready", bus.in_ready, 1);

    // Random transactions, occasionally with a stuck bit
    repeat (60) begin
      stuck = ($urandom_range(0, 3) == 0);
      set_bank(W'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(W'($urandom));
      wait_idle(20);
      stuck = 1'b0;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
